// File: rtl/strobe_pkg.sv
// Shared types and constants for the 3-to-8 strobe decoder.
// Holds the FSM encoding, bus geometry and the one-hot helper.
package strobe_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_LINES - 1);

    function automatic logic [NUM_LINES-1:0] onehot_of(
        input logic [CODE_W-1:0] code
    );
        logic [NUM_LINES-1:0] one;
        one = NUM_LINES'(1);
        return one << code;
    endfunction

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter used to time each strobe.
// Load wins over tick; the count saturates at zero.
module strobe_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/strobe_decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with hold timer and line-scan mode.
// FSM picks single-strobe or walk; timer sets the per-line hold width.
module strobe_decoder_3to8
    import strobe_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CODE_W-1:0]    Din,
    input  logic                 Din_valid,
    output logic                 Din_ready,
    input  logic                 scan,
    output logic [NUM_LINES-1:0] Dout,
    output logic                 Dout_valid,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t state;
    state_t state_nxt;

    logic [CODE_W-1:0]    idx;
    logic [CODE_W-1:0]    idx_nxt;
    logic [NUM_LINES-1:0] dout_nxt;
    logic                 valid_nxt;

    logic             t_clr;
    logic             t_load;
    logic             t_tick;
    logic [CNT_W-1:0] t_count;
    logic             t_zero;

    logic accept;
    logic scan_start;
    logic last_line;

    assign Din_ready  = (state == IDLE) && !en;
    assign accept     = Din_ready && Din_valid;
    assign scan_start = Din_ready && !Din_valid && scan;
    assign last_line  = (idx == LAST_IDX);
    assign busy       = (state != IDLE);

    strobe_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (t_clr),
        .load  (t_load),
        .value (RELOAD),
        .tick  (t_tick),
        .count (t_count),
        .zero  (t_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = HOLD;
                    end else if (scan_start) begin
                        state_nxt = SCAN;
                    end
                end
                HOLD: begin
                    if (t_zero) begin
                        state_nxt = IDLE;
                    end
                end
                SCAN: begin
                    if (t_zero && last_line) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the registered bus, scan index and timer controls.
    always_comb begin
        dout_nxt  = Dout;
        valid_nxt = Dout_valid;
        idx_nxt   = idx;
        t_clr     = 1'b0;
        t_load    = 1'b0;
        t_tick    = 1'b0;
        if (en) begin
            dout_nxt  = '0;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
            t_clr     = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dout_nxt  = onehot_of(Din);
                        valid_nxt = 1'b1;
                        t_load    = 1'b1;
                    end else if (scan_start) begin
                        dout_nxt  = onehot_of('0);
                        valid_nxt = 1'b1;
                        idx_nxt   = '0;
                        t_load    = 1'b1;
                    end
                end
                HOLD: begin
                    if (t_zero) begin
                        dout_nxt  = '0;
                        valid_nxt = 1'b0;
                    end else begin
                        t_tick = 1'b1;
                    end
                end
                SCAN: begin
                    if (!t_zero) begin
                        t_tick = 1'b1;
                    end else if (last_line) begin
                        dout_nxt  = '0;
                        valid_nxt = 1'b0;
                        idx_nxt   = '0;
                    end else begin
                        dout_nxt = Dout << 1;
                        idx_nxt  = idx + 1'b1;
                        t_load   = 1'b1;
                    end
                end
                default: begin
                    dout_nxt  = '0;
                    valid_nxt = 1'b0;
                    idx_nxt   = '0;
                    t_clr     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dout       <= '0;
            Dout_valid <= 1'b0;
            idx        <= '0;
        end else begin
            Dout       <= dout_nxt;
            Dout_valid <= valid_nxt;
            idx        <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_strobe_decoder_3to8.sv
// Directed bench for strobe_decoder_3to8 with HOLD_CYCLES=4.
// Inputs change 1 ns after each rising edge; outputs are checked there.
module tb_strobe_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] Din = 3'd0;
    logic       Din_valid = 1'b0;
    logic       Din_ready;
    logic       scan = 1'b0;
    logic [7:0] Dout;
    logic       Dout_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    strobe_decoder_3to8 #(
        .HOLD_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Din_ready  (Din_ready),
        .scan       (scan),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (Dout_valid && !$onehot(Dout)) begin
                errors++;
                $display("FAIL onehot: Dout=%h with Dout_valid=1", Dout);
            end
            if (!Dout_valid && Dout !== 8'h00) begin
                errors++;
                $display("FAIL idle_zero: Dout=%h with Dout_valid=0", Dout);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        checks++;
        if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: Dout=%h v=%b busy=%b want 00 0 0",
                     Dout, Dout_valid, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (Din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: Din_ready=%b want 1", Din_ready);
        end
        step();
    endtask

    task automatic test_single();
        Din = 3'b101;
        Din_valid = 1'b1;
        step();
        Din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (Dout !== 8'h20 || Din_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_c%0d: Dout=%h rdy=%b busy=%b want 20 0 1",
                         i, Dout, Din_ready, busy);
            end
            step();
        end
        checks++;
        if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: Dout=%h v=%b busy=%b want 00 0 0",
                     Dout, Dout_valid, busy);
        end
        step();
    endtask

    task automatic test_scan();
        logic [7:0] exp;
        scan = 1'b1;
        step();
        scan = 1'b0;
        exp = 8'h01;
        for (int line = 0; line < 8; line++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (Dout !== exp || Dout_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL scan_l%0d_c%0d: Dout=%h v=%b want %h 1",
                             line, c, Dout, Dout_valid, exp);
                end
                step();
            end
            exp = exp << 1;
        end
        checks++;
        if (Dout !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_end: Dout=%h busy=%b want 00 0", Dout, busy);
        end
        step();
    endtask

    task automatic test_priority();
        Din = 3'b010;
        Din_valid = 1'b1;
        scan = 1'b1;
        step();
        Din_valid = 1'b0;
        scan = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (Dout !== 8'h04) begin
                errors++;
                $display("FAIL prio_c%0d: Dout=%h want 04", i, Dout);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (Dout !== 8'h00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL prio_noscan%0d: Dout=%h busy=%b want 00 0",
                         i, Dout, busy);
            end
            step();
        end
    endtask

    task automatic test_abort();
        Din = 3'd3;
        Din_valid = 1'b1;
        step();
        Din_valid = 1'b0;
        checks++;
        if (Dout !== 8'h08) begin
            errors++;
            $display("FAIL abort_start: Dout=%h want 08", Dout);
        end
        step();
        en = 1'b1;
        Din = 3'd6;
        Din_valid = 1'b1;
        #1;
        checks++;
        if (Din_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rdy: Din_ready=%b want 0", Din_ready);
        end
        step();
        checks++;
        if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_clr: Dout=%h v=%b busy=%b want 00 0 0",
                     Dout, Dout_valid, busy);
        end
        step();
        checks++;
        if (Dout !== 8'h00 || busy !== 1'b0 || Din_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: Dout=%h busy=%b rdy=%b want 00 0 0",
                     Dout, busy, Din_ready);
        end
        Din_valid = 1'b0;
        en = 1'b0;
        #1;
        checks++;
        if (Din_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_resume: Din_ready=%b want 1", Din_ready);
        end
        step();
    endtask

    task automatic test_async_reset();
        scan = 1'b1;
        step();
        scan = 1'b0;
        repeat (12) step();
        checks++;
        if (Dout !== 8'h08) begin
            errors++;
            $display("FAIL arst_pre: Dout=%h want 08", Dout);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (Dout !== 8'h00 || Dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: Dout=%h v=%b busy=%b want 00 0 0",
                     Dout, Dout_valid, busy);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (Dout !== 8'h00 || busy !== 1'b0 || Din_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_after: Dout=%h busy=%b rdy=%b want 00 0 1",
                     Dout, busy, Din_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_priority();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
